voice_fifo_arbiter: RTL and testbench
=====================================

Name: voice_fifo_arbiter

Overview:
- Round-robin write-side scheduler that shares one voice sample FIFO (3-bit address, 8 entries, no full flag) among NCH voice channel sources.
- Tags each granted sample with its channel index and drives the FIFO write port.
- Tracks FIFO occupancy with a credit counter so the FIFO is never overrun; credits return as consumer-side pulses already synchronised into i_clk.
- Sits in the FIFO write-clock domain, between the codec channel front-ends and the FIFO.

Parameters:
- NCH, 4, number of requesting channels (2..8).
- DSIZE, 16, sample width in bits.
- DEPTH, 8, FIFO entries (power of two), which is the initial credit count.
- CHW, 2, channel-tag width; must equal clog2(NCH).

Ports:
- i_clk  input  1  single clock; FIFO write clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_en  input  1  enable; low means no new grants are issued.
- i_req  input  NCH  per-channel request; held with data until granted.
- i_data  input  NCH*DSIZE  channel k sample at bits [k*DSIZE +: DSIZE].
- o_gnt  output  NCH  one-hot, combinational, one-cycle accept pulse.
- o_wr_req  output  1  registered FIFO write strobe.
- o_wr_data  output  DSIZE+CHW  registered {chan_id, sample}.
- i_credit  input  1  one pulse per entry drained by the consumer.
- o_credits  output  clog2(DEPTH)+1  current free-entry count.
- o_state  output  2  FSM state, for debug.
- o_err  output  1  sticky overflow/underflow error flag.

Behaviour:
- Reset, asynchronous and immediate:
  - o_wr_req=0, o_wr_data=0, o_gnt=0.
  - credits=DEPTH, rr pointer=0, state=IDLE, o_err=0.
- Reset mid-operation discards the in-flight registered write. The FIFO is reset with the same event.
- FSM states: IDLE=0, RUN=1, STALL=2.
  - IDLE -> RUN when i_en=1.
  - RUN -> STALL when the effective credit count becomes 0 after this cycle's update.
  - STALL -> RUN when credits>0.
  - Any state -> IDLE when i_en=0. Transitions take effect on the next clock edge.
- Grant rules:
  - A grant is issued only in RUN with credits>0 and at least one i_req bit set.
  - Grant goes to the first requesting channel, searching upward with wraparound from (ptr). ptr is the channel after the last granted one.
  - On a grant, ptr <= granted+1, wrapping at NCH.
  - At most one grant per cycle. No grants in IDLE or STALL.
- Handshake and latency:
  - o_gnt[k]=1 in cycle T means i_data[k] is sampled at the T edge.
  - o_wr_req=1 with o_wr_data={k, sample} in cycle T+1.
  - Requester may drop or change i_req and data after T.
- Credit arithmetic:
  - A grant decrements credits; i_credit increments them.
  - Grant and i_credit in the same cycle leave credits unchanged.
  - A grant is allowed at credits=0 only if i_credit=1 that cycle; credits stay 0 and the FSM stays in RUN.
- Boundaries:
  - i_credit at credits=DEPTH with no grant: ignored, and o_err set.
  - Credits never wrap. o_err clears only on reset.
- i_en deasserted mid-stream:
  - The pending registered write still completes.
  - Credits keep counting returns in IDLE.

Optional Feature:
- Macro VOICE_ARB_PRIO0_EN:
  - Defined: channel 0 has strict priority. If i_req[0]=1 and a grant is allowed, channel 0 wins regardless of ptr, and ptr is left unchanged.
  - Undefined: pure round-robin for all channels, as above.

Decomposition:
- Package voice_pkg holds:
  - FSM state encodings: ST_IDLE, ST_RUN, ST_STALL.
  - Defaults VOICE_DSIZE=16 and VOICE_FIFO_DEPTH=8.
  - A clog2 helper function.
- One sub-module, voice_rr_pick: combinational one-hot rotating priority picker. Inputs are req and ptr; outputs are one-hot grant and granted index.
- FSM, credit counter and output registers stay in voice_fifo_arbiter.

Test Plan:
- Reset, then i_en=1 with i_req=4'b1111 held and no credits returned:
  - Grants go 0,1,2,3,0,1,2,3 on consecutive cycles.
  - Credits fall 8->0 and the FSM enters STALL; no 9th grant.
  - o_wr_data tags match with 1-cycle latency.
- From STALL, pulse i_credit once:
  - credits=1, STALL->RUN.
  - Exactly one grant to channel 0 (ptr wrapped), then STALL again.
- Credits=0 in RUN with i_req=4'b0100 and i_credit=1 in the same cycle:
  - Channel 2 granted, credits stay 0, o_err=0.
- Credits=8 with i_credit pulsed and no requests:
  - Credits stay 8 and o_err=1, sticky until i_rst.
- i_req=4'b1010 with ptr=2:
  - Channel 3 granted then channel 1.
  - With VOICE_ARB_PRIO0_EN and i_req=4'b1011: channel 0 is granted on every allowed cycle.
- Assert i_rst asynchronously with o_wr_req high mid-cycle:
  - o_wr_req=0 and credits=8 immediately, before the next edge.
  - state=IDLE.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared definitions for the voice FIFO write-side arbiter:
// FSM state encodings, default sizes and a constant-foldable clog2 helper.
package voice_pkg;

  // Arbiter FSM states; the encoding is visible on o_state for debug.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  localparam int VOICE_DSIZE      = 16;
  localparam int VOICE_FIFO_DEPTH = 8;

  // Ceiling log2 for sizing ports and counters at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage : voice_pkg

// File: rtl/voice_rr_pick.sv
// Rotating-priority picker: scans req upward from ptr with wraparound and
// returns the first requester as a one-hot grant plus its binary index.
// Purely combinational; the caller decides whether the grant is used.
module voice_rr_pick
  import voice_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] idx
);

  logic found;
  int   chan;

  // First requester at or after ptr, wrapping at NCH, wins.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the loop leaves one unassigned and no latch is inferred.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    chan  = 0;
    for (int i = 0; i < NCH; i++) begin
      chan = (int'(ptr) + i) % NCH;
      if (!found && req[chan]) begin
        gnt[chan] = 1'b1;
        idx       = CHW'(chan);
        found     = 1'b1;
      end
    end
  end

endmodule : voice_rr_pick

// File: rtl/voice_fifo_arbiter.sv
// Write-side scheduler for a shared voice sample FIFO.
// Round-robins NCH channel requests onto one FIFO write port, tags each
// sample with its channel index and gates grants on a credit counter that
// mirrors the FIFO's free entries (credits return as pre-synchronised
// i_credit pulses).
// Optional build macro: VOICE_ARB_PRIO0_EN -- channel 0 gets strict
// priority over the rotation and does not move the round-robin pointer.
module voice_fifo_arbiter
  import voice_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DSIZE = VOICE_DSIZE,
  parameter int DEPTH = VOICE_FIFO_DEPTH,
  parameter int CHW   = clog2(NCH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [NCH-1:0]         i_req,
  input  logic [NCH*DSIZE-1:0]   i_data,
  output logic [NCH-1:0]         o_gnt,
  output logic                   o_wr_req,
  output logic [DSIZE+CHW-1:0]   o_wr_data,
  input  logic                   i_credit,
  output logic [clog2(DEPTH):0]  o_credits,
  output logic [1:0]             o_state,
  output logic                   o_err
);

  localparam int               CW   = clog2(DEPTH) + 1;
  localparam logic [CW-1:0]    FULL = CW'(DEPTH);
  localparam logic [CHW-1:0]   LAST = CHW'(NCH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    credits, credits_next;
  logic [CHW-1:0]   ptr, ptr_next;
  logic [NCH-1:0]   rr_gnt, sel_gnt;
  logic [CHW-1:0]   rr_idx, sel_idx;
  logic             ptr_adv;
  logic             grant;
  logic             credit_err;
  logic             stall;
  logic [DSIZE-1:0] sample;

  voice_rr_pick #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_pick (
    .req (i_req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

`ifdef VOICE_ARB_PRIO0_EN
  // Channel 0 overrides the rotation and leaves the pointer where it was.
  always_comb begin
    sel_gnt = rr_gnt;
    sel_idx = rr_idx;
    ptr_adv = 1'b1;
    if (i_req[0]) begin
      sel_gnt = NCH'(1);
      sel_idx = '0;
      ptr_adv = 1'b0;
    end
  end
`else
  // Pure round-robin: the picker's choice is final.
  always_comb begin
    sel_gnt = rr_gnt;
    sel_idx = rr_idx;
    ptr_adv = 1'b1;
  end
`endif

  // A grant needs RUN, a requester, and a free entry now or one freed this
  // cycle by a returning credit.
  assign grant = i_en && (state == ST_RUN) && (|i_req) &&
                 ((credits != '0) || i_credit);

  assign o_gnt     = grant ? sel_gnt : '0;
  assign sample    = i_data[int'(sel_idx)*DSIZE +: DSIZE];
  assign o_credits = credits;
  assign o_state   = state;

  // Credit update: grant consumes, return refills, both together cancel.
  always_comb begin
    credits_next = credits;
    credit_err   = 1'b0;
    unique case ({grant, i_credit})
      2'b10: begin
        if (credits == '0) credit_err   = 1'b1;
        else               credits_next = credits - 1'b1;
      end
      2'b01: begin
        if (credits == FULL) credit_err   = 1'b1;
        else                 credits_next = credits + 1'b1;
      end
      default: credits_next = credits;
    endcase
  end

  // Stall once the pool runs dry, except when a grant rode on a credit that
  // arrived in the same cycle (the count was already zero and stays so).
  assign stall = (credits_next == '0) && !(grant && i_credit);

  // Next-state logic; i_en low forces IDLE from anywhere.
  always_comb begin
    state_next = state;
    if (!i_en) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:  state_next = ST_RUN;
        ST_RUN:   if (stall) state_next = ST_STALL;
        ST_STALL: if (credits != '0) state_next = ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Pointer moves to the channel after the one just granted, wrapping at NCH.
  always_comb begin
    ptr_next = ptr;
    if (grant && ptr_adv) begin
      ptr_next = (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
    end
  end

  // Control state: FSM, credit pool, rotation pointer and sticky error.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      state   <= ST_IDLE;
      credits <= FULL;
      ptr     <= '0;
      o_err   <= 1'b0;
    end else begin
      state   <= state_next;
      credits <= credits_next;
      ptr     <= ptr_next;
      if (credit_err) o_err <= 1'b1;
    end
  end

  // Registered FIFO write port: the granted sample, tagged, one cycle later.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wr_req  <= 1'b0;
      o_wr_data <= '0;
    end else begin
      o_wr_req <= grant;
      if (grant) o_wr_data <= {sel_idx, sample};
    end
  end

endmodule : voice_fifo_arbiter

// File: tb/tb_voice_fifo_arbiter.sv
// Directed self-checking bench for voice_fifo_arbiter (NCH=4, DEPTH=8).
// Granted samples are pushed to a scoreboard when o_gnt is observed and
// popped when the registered FIFO write appears one edge later.
module tb_voice_fifo_arbiter;

`ifdef VOICE_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [63:0] data = '0;
  logic        credit = 1'b0;
  logic [3:0]  gnt;
  logic        wr_req;
  logic [17:0] wr_data;
  logic [3:0]  credits;
  logic [1:0]  state;
  logic        err;

  logic [15:0] samp [4];
  logic [17:0] sb [$];
  int          n_total = 0;
  int          n_pass  = 0;
  int          step    = 0;

  voice_fifo_arbiter dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_en      (en),
    .i_req     (req),
    .i_data    (data),
    .o_gnt     (gnt),
    .o_wr_req  (wr_req),
    .o_wr_data (wr_data),
    .i_credit  (credit),
    .o_credits (credits),
    .o_state   (state),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL step%0d %s: observed %0h expected %0h", step, tag, obs, exp);
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  // One clock: drive at negedge, check combinational grant, then check the
  // registered write, credits, state and error flag just after the edge.
  task automatic cyc(input logic e, input logic [3:0] r, input logic c,
                     input logic [3:0] exp_gnt, input int exp_cred,
                     input logic [1:0] exp_st, input logic exp_err);
    logic [17:0] exp_wr;
    @(negedge clk);
    step++;
    en = e;
    req = r;
    credit = c;
    for (int i = 0; i < 4; i++) samp[i] = 16'($urandom);
    data = {samp[3], samp[2], samp[1], samp[0]};
    #1;
    check("gnt", 32'(gnt), 32'(exp_gnt));
    if (exp_gnt != '0) sb.push_back({onehot_idx(exp_gnt), samp[onehot_idx(exp_gnt)]});
    @(posedge clk);
    #1;
    check("wr_req", 32'(wr_req), 32'(sb.size() != 0));
    if (wr_req && sb.size() != 0) begin
      exp_wr = sb.pop_front();
      check("wr_data", 32'(wr_data), 32'(exp_wr));
    end
    check("credits", 32'(credits), 32'(exp_cred));
    check("state", 32'(state), 32'(exp_st));
    check("err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    // Reset values while reset is held.
    #12;
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_credits", 32'(credits), 32'd8);
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // All four channels requesting, no returns: 8 grants then STALL.
    cyc(1, 4'b1111, 0, 4'b0000, 8, S_RUN, 0);
    for (int k = 0; k < 8; k++)
      cyc(1, 4'b1111, 0, PRIO0 ? 4'b0001 : 4'(1 << (k % 4)), 7 - k,
          (k < 7) ? S_RUN : S_STALL, 0);
    cyc(1, 4'b1111, 0, 4'b0000, 0, S_STALL, 0);

    // One credit back: STALL -> RUN, one grant to channel 0, STALL again.
    cyc(1, 4'b1111, 1, 4'b0000, 1, S_STALL, 0);
    cyc(1, 4'b1111, 0, 4'b0000, 1, S_RUN, 0);
    cyc(1, 4'b1111, 0, 4'b0001, 0, S_STALL, 0);
    cyc(1, 4'b1111, 0, 4'b0000, 0, S_STALL, 0);

    // Through IDLE into RUN with zero credits, then grant on a same-cycle return.
    cyc(0, 4'b0000, 0, 4'b0000, 0, S_IDLE, 0);
    cyc(1, 4'b0000, 0, 4'b0000, 0, S_RUN, 0);
    cyc(1, 4'b0100, 1, 4'b0100, 0, S_RUN, 0);

    // Build credits and set ptr=2 via a channel-1 grant.
    cyc(1, 4'b0000, 1, 4'b0000, 1, S_RUN, 0);
    cyc(1, 4'b0010, 1, 4'b0010, 1, S_RUN, 0);
    cyc(1, 4'b0000, 1, 4'b0000, 2, S_RUN, 0);

    // Sparse requests from ptr=2 (or channel-0 priority when enabled).
    if (PRIO0) begin
      cyc(1, 4'b1011, 0, 4'b0001, 1, S_RUN, 0);
      cyc(1, 4'b1011, 0, 4'b0001, 0, S_STALL, 0);
    end else begin
      cyc(1, 4'b1010, 0, 4'b1000, 1, S_RUN, 0);
      cyc(1, 4'b1010, 0, 4'b0010, 0, S_STALL, 0);
    end

    // Refill to DEPTH, then an extra return overflows: ignored, sticky err.
    for (int k = 0; k < 8; k++)
      cyc(1, 4'b0000, 1, 4'b0000, k + 1, (k == 0) ? S_STALL : S_RUN, 0);
    cyc(1, 4'b0000, 1, 4'b0000, 8, S_RUN, 1);
    cyc(1, 4'b0000, 0, 4'b0000, 8, S_RUN, 1);
    cyc(0, 4'b0000, 0, 4'b0000, 8, S_IDLE, 1);

    // Async reset mid-cycle while a write is in flight.
    cyc(1, 4'b0000, 0, 4'b0000, 8, S_RUN, 1);
    cyc(1, 4'b0001, 0, 4'b0001, 7, S_RUN, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("arst_wr_req", 32'(wr_req), 32'd0);
    check("arst_credits", 32'(credits), 32'd8);
    check("arst_state", 32'(state), 32'(S_IDLE));
    check("arst_err", 32'(err), 32'd0);
    check("arst_gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    req = '0;
    cyc(1, 4'b0000, 0, 4'b0000, 8, S_RUN, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_voice_fifo_arbiter
